// File: rtl/lpddr2_poll_pkg.sv
// Shared types and constants for the LPDDR2 calibration status poller.
package lpddr2_poll_pkg;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned INIT_DONE   = 0;
  localparam int unsigned CAL_SUCCESS = 1;
  localparam int unsigned CAL_FAIL    = 2;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RDWAIT,
    EVAL,
    GAP
  } state_t;

endpackage

// File: rtl/avm_single_read.sv
// One-shot Avalon-MM read: holds the request through waitrequest, then
// captures readdata[2:0] a fixed number of cycles after the accept edge.
module avm_single_read
  import lpddr2_poll_pkg::*;
#(
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned STATUS_ADDR  = 0,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              launch,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              accept_c,
  output logic              done_c,
  output logic [2:0]        data
);

  localparam int unsigned LAT_W = 3;

  logic             pending;
  logic [LAT_W-1:0] lat_cnt;
  logic             unused_hi;

  assign unused_hi = ^avm_readdata[31:3];
  assign accept_c  = avm_read && !avm_waitrequest;
  assign done_c    = pending && (lat_cnt == LAT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= '0;
      pending     <= 1'b0;
      lat_cnt     <= '0;
      data        <= '0;
    end else begin
      if (launch) begin
        avm_read    <= 1'b1;
        avm_address <= ADDR_W'(STATUS_ADDR);
      end else if (accept_c) begin
        avm_read    <= 1'b0;
        avm_address <= '0;
      end

      // Latency countdown; data is taken on the edge where the count is 1.
      if (accept_c) begin
        pending <= 1'b1;
        lat_cnt <= LAT_W'(READ_LATENCY);
      end else if (done_c) begin
        pending <= 1'b0;
        data    <= avm_readdata[2:0];
      end else if (pending) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lpddr2_status_poller.sv
// Polls the LPDDR2 status PIO until calibration passes, fails or the poll
// budget runs out, and reports the sticky outcome to boot sequencing.
module lpddr2_status_poller
  import lpddr2_poll_pkg::*;
#(
  parameter int unsigned ADDR_W        = 2,
  parameter int unsigned STATUS_ADDR   = 0,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned POLL_INTERVAL = 256,
  parameter int unsigned MAX_POLLS     = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic              busy,
  output logic              cal_pass,
  output logic              cal_fail,
  output logic              timeout,
  output logic [2:0]        last_status
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] poll_cnt, poll_cnt_nxt;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
  logic             cal_pass_nxt, cal_fail_nxt, timeout_nxt;
  logic             launch_c, accept_c, done_c;
  logic [2:0]       rd_data;

  avm_single_read #(
    .ADDR_W      (ADDR_W),
    .STATUS_ADDR (STATUS_ADDR),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd (
    .clk            (clk),
    .reset          (reset),
    .launch         (launch_c),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .accept_c       (accept_c),
    .done_c         (done_c),
    .data           (rd_data)
  );

  assign last_status = rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      poll_cnt <= '0;
      gap_cnt  <= '0;
      busy     <= 1'b0;
      cal_pass <= 1'b0;
      cal_fail <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      poll_cnt <= poll_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      busy     <= (state_nxt != IDLE);
      cal_pass <= cal_pass_nxt;
      cal_fail <= cal_fail_nxt;
      timeout  <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    poll_cnt_nxt = poll_cnt;
    gap_cnt_nxt  = gap_cnt;
    cal_pass_nxt = cal_pass;
    cal_fail_nxt = cal_fail;
    timeout_nxt  = timeout;
    launch_c     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          cal_pass_nxt = 1'b0;
          cal_fail_nxt = 1'b0;
          timeout_nxt  = 1'b0;
          poll_cnt_nxt = '0;
          launch_c     = 1'b1;
          state_nxt    = REQ;
        end
      end
      REQ: begin
        if (accept_c) state_nxt = RDWAIT;
      end
      RDWAIT: begin
        if (done_c) begin
          if (poll_cnt != '1) poll_cnt_nxt = poll_cnt + CNT_W'(1);
          state_nxt = EVAL;
        end
      end
      // Fail outranks pass, and any result outranks the poll budget.
      EVAL: begin
        if (rd_data[CAL_FAIL]) begin
          cal_fail_nxt = 1'b1;
          state_nxt    = IDLE;
        end else if (rd_data[CAL_SUCCESS] && rd_data[INIT_DONE]) begin
          cal_pass_nxt = 1'b1;
          state_nxt    = IDLE;
        end else if (poll_cnt == CNT_W'(MAX_POLLS)) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          gap_cnt_nxt = CNT_W'(POLL_INTERVAL);
          state_nxt   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt <= CNT_W'(1)) begin
          launch_c  = 1'b1;
          state_nxt = REQ;
        end else begin
          gap_cnt_nxt = gap_cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lpddr2_status_poller.sv
// Directed bench for lpddr2_status_poller: a table of polling sessions on a
// READ_LATENCY=1 instance plus hand sequences on a READ_LATENCY=3 instance.
module tb_lpddr2_status_poller;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned SADDR  = 1;
  localparam int unsigned PI     = 4;
  localparam int unsigned MP     = 8;
  localparam logic [31:0] GARBAGE = 32'hFFFF_FFFC;
  localparam int NV = 11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start_s [2];
  logic              wr_s    [2];
  logic [31:0]       rdata_s [2];
  logic              rd_o    [2];
  logic [ADDR_W-1:0] addr_o  [2];
  logic              busy_o  [2];
  logic              pass_o  [2];
  logic              fail_o  [2];
  logic              to_o    [2];
  logic [2:0]        ls_o    [2];

  lpddr2_status_poller #(.ADDR_W(ADDR_W), .STATUS_ADDR(SADDR), .READ_LATENCY(1),
                         .POLL_INTERVAL(PI), .MAX_POLLS(MP)) dut (
    .clk(clk), .reset(reset), .start(start_s[0]),
    .avm_address(addr_o[0]), .avm_read(rd_o[0]),
    .avm_waitrequest(wr_s[0]), .avm_readdata(rdata_s[0]),
    .busy(busy_o[0]), .cal_pass(pass_o[0]), .cal_fail(fail_o[0]),
    .timeout(to_o[0]), .last_status(ls_o[0]));

  lpddr2_status_poller #(.ADDR_W(ADDR_W), .STATUS_ADDR(SADDR), .READ_LATENCY(3),
                         .POLL_INTERVAL(PI), .MAX_POLLS(MP)) dut_rl3 (
    .clk(clk), .reset(reset), .start(start_s[1]),
    .avm_address(addr_o[1]), .avm_read(rd_o[1]),
    .avm_waitrequest(wr_s[1]), .avm_readdata(rdata_s[1]),
    .busy(busy_o[1]), .cal_pass(pass_o[1]), .cal_fail(fail_o[1]),
    .timeout(to_o[1]), .last_status(ls_o[1]));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: per-read status word (octal digit i = read i), stalls,
  // and readdata valid only on the cycle the capture edge must sample.
  int          rl         [2] = '{1, 3};
  logic [23:0] resp       [2];
  int          stall_cfg  [2];
  int          stall_left [2];
  int          lat_cnt    [2];
  int          cur_idx    [2];
  int          nreads     [2];
  logic        prev_stall [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      wr_s[k] = 1'b0; rdata_s[k] = GARBAGE; lat_cnt[k] = 0;
      prev_stall[k] = 1'b0; nreads[k] = 0; cur_idx[k] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (lat_cnt[k] > 0) begin
          lat_cnt[k]--;
          if (lat_cnt[k] == 0 && cur_idx[k] < 8)
            rdata_s[k] = {29'd0, resp[k][3*cur_idx[k] +: 3]};
          else
            rdata_s[k] = GARBAGE;
        end else begin
          rdata_s[k] = GARBAGE;
        end
        if (reset) begin
          wr_s[k] = 1'b0; prev_stall[k] = 1'b0; lat_cnt[k] = 0;
        end else begin
          if (prev_stall[k]) chk($sformatf("req_hold%0d", k), 32'(rd_o[k]), 32'd1);
          if (rd_o[k]) begin
            chk($sformatf("req_addr%0d", k), 32'(addr_o[k]), SADDR);
            if (stall_left[k] > 0) begin
              wr_s[k] = 1'b1; stall_left[k]--; prev_stall[k] = 1'b1;
            end else begin
              wr_s[k] = 1'b0; prev_stall[k] = 1'b0;
              lat_cnt[k] = rl[k]; cur_idx[k] = nreads[k]; nreads[k]++;
              stall_left[k] = stall_cfg[k];
            end
          end else begin
            wr_s[k] = 1'b0; prev_stall[k] = 1'b0;
          end
        end
      end
    end
  end

  function automatic int exp_busy(input int n, input int stall, input int lat);
    return n * (2 + stall + lat) + (n - 1) * int'(PI);
  endfunction

  // Pulse start, optionally pulse it again 'mid' busy cycles in, and count busy cycles.
  task automatic session(input int k, input int mid, output int cyc);
    int guard;
    nreads[k] = 0;
    stall_left[k] = stall_cfg[k];
    @(negedge clk); start_s[k] = 1'b1;
    @(negedge clk); start_s[k] = 1'b0;
    chk($sformatf("start_clears%0d", k), 32'({pass_o[k], fail_o[k], to_o[k]}), 32'd0);
    cyc = 0; guard = 0;
    while (busy_o[k] && guard < 3000) begin
      start_s[k] = (cyc == mid);
      cyc++; guard++;
      @(negedge clk);
    end
    start_s[k] = 1'b0;
    if (guard >= 3000) chk($sformatf("session_bound%0d", k), 32'd1, 32'd0);
  endtask

  typedef struct {
    logic [23:0] s;
    int          stall;
    int          reads;
    logic        pass;
    logic        fail;
    logic        to;
    logic [2:0]  last;
  } vec_t;

  vec_t vecs [NV];
  int   cyc;

  initial begin
    vecs[0]  = '{24'o00000300, 0, 3, 1'b1, 1'b0, 1'b0, 3'd3};
    vecs[1]  = '{24'o00000007, 0, 1, 1'b0, 1'b1, 1'b0, 3'd7};
    vecs[2]  = '{24'o11111111, 0, 8, 1'b0, 1'b0, 1'b1, 3'd1};
    vecs[3]  = '{24'o00000051, 0, 2, 1'b0, 1'b1, 1'b0, 3'd5};
    vecs[4]  = '{24'o00000032, 5, 2, 1'b1, 1'b0, 1'b0, 3'd3};
    vecs[5]  = '{24'o00000003, 2, 1, 1'b1, 1'b0, 1'b0, 3'd3};
    vecs[6]  = '{24'o22222222, 1, 8, 1'b0, 1'b0, 1'b1, 3'd2};
    vecs[7]  = '{24'o00007111, 0, 4, 1'b0, 1'b1, 1'b0, 3'd7};
    vecs[8]  = '{24'o00000006, 0, 1, 1'b0, 1'b1, 1'b0, 3'd6};
    vecs[9]  = '{24'o30000000, 0, 8, 1'b1, 1'b0, 1'b0, 3'd3};
    vecs[10] = '{24'o70000000, 0, 8, 1'b0, 1'b1, 1'b0, 3'd7};

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0; stall_cfg[k] = 0; stall_left[k] = 0; resp[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_outputs%0d", k),
          32'({rd_o[k], addr_o[k], busy_o[k], pass_o[k], fail_o[k], to_o[k], ls_o[k]}), 32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      resp[0] = vecs[i].s;
      stall_cfg[0] = vecs[i].stall;
      session(0, -1, cyc);
      chk($sformatf("vec%0d_reads", i), 32'(nreads[0]), 32'(vecs[i].reads));
      chk($sformatf("vec%0d_pass", i), 32'(pass_o[0]), 32'(vecs[i].pass));
      chk($sformatf("vec%0d_fail", i), 32'(fail_o[0]), 32'(vecs[i].fail));
      chk($sformatf("vec%0d_timeout", i), 32'(to_o[0]), 32'(vecs[i].to));
      chk($sformatf("vec%0d_last", i), 32'(ls_o[0]), 32'(vecs[i].last));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(cyc),
          32'(exp_busy(vecs[i].reads, vecs[i].stall, 1)));
    end

    // Latency-3 instance with 5-cycle stalls, then without stalls.
    resp[1] = 24'o00000032; stall_cfg[1] = 5;
    session(1, -1, cyc);
    chk("rl3_stall_reads", 32'(nreads[1]), 32'd2);
    chk("rl3_stall_pass", 32'({pass_o[1], fail_o[1], to_o[1]}), 32'b100);
    chk("rl3_stall_last", 32'(ls_o[1]), 32'd3);
    chk("rl3_stall_busy", 32'(cyc), 32'(exp_busy(2, 5, 3)));
    resp[1] = 24'o00000007; stall_cfg[1] = 0;
    session(1, -1, cyc);
    chk("rl3_fail", 32'({pass_o[1], fail_o[1], to_o[1]}), 32'b010);
    chk("rl3_fail_busy", 32'(cyc), 32'(exp_busy(1, 0, 3)));

    // Start while busy is ignored; start after timeout restarts the count.
    resp[0] = 24'o11111111; stall_cfg[0] = 0;
    session(0, 10, cyc);
    chk("ignore_reads", 32'(nreads[0]), 32'd8);
    chk("ignore_timeout", 32'(to_o[0]), 32'd1);
    chk("ignore_busy", 32'(cyc), 32'(exp_busy(8, 0, 1)));
    session(0, -1, cyc);
    chk("restart_reads", 32'(nreads[0]), 32'd8);
    chk("restart_timeout", 32'(to_o[0]), 32'd1);
    chk("restart_busy", 32'(cyc), 32'(exp_busy(8, 0, 1)));

    // Reset while a read is stalled in REQ.
    resp[0] = 24'o00000003; stall_cfg[0] = 100;
    stall_left[0] = 100; nreads[0] = 0;
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_req", 32'({rd_o[0], busy_o[0]}), 32'b11);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rst_in_req",
        32'({rd_o[0], addr_o[0], busy_o[0], pass_o[0], fail_o[0], to_o[0], ls_o[0]}), 32'd0);
    stall_cfg[0] = 0;
    session(0, -1, cyc);
    chk("post_rst_reads", 32'(nreads[0]), 32'd1);
    chk("post_rst_result", 32'({pass_o[0], fail_o[0], to_o[0]}), 32'b100);
    chk("post_rst_busy", 32'(cyc), 32'(exp_busy(1, 0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
